// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver with blanking, double buffering and registered outputs.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is never suppressed).
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] HEX,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic                    LOAD,
    output logic [7:0]              CATHODES,
    output logic [NUM_DIGITS-1:0]   ANODES,
    output logic                    FRAME_DONE
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_end;
    logic                    idx_ok;

    logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d, act_hex_q, act_hex_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic                    pend_valid_q, pend_valid_d;

    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    shown;
    logic [3:0]              nibble;
    logic [7:0]              cathodes_q, cathodes_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    frame_done_q, frame_done_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b1111110;
            4'h1: seg_decode = 7'b0110000;
            4'h2: seg_decode = 7'b1101101;
            4'h3: seg_decode = 7'b1111001;
            4'h4: seg_decode = 7'b0110011;
            4'h5: seg_decode = 7'b1011011;
            4'h6: seg_decode = 7'b1011111;
            4'h7: seg_decode = 7'b1110000;
            4'h8: seg_decode = 7'b1111111;
            4'h9: seg_decode = 7'b1111011;
            4'hA: seg_decode = 7'b1110111;
            4'hB: seg_decode = 7'b0011111;
            4'hC: seg_decode = 7'b1001110;
            4'hD: seg_decode = 7'b0111101;
            4'hE: seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    assign idx_ok = (32'(idx_q) < NUM_DIGITS);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (!idx_ok) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d     = '0;
                        frame_end = (idx_q == IDX_LAST);
                        idx_d     = frame_end ? '0 : idx_q + 1'b1;
                        state_d   = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // The boundary transfer reads pending before this cycle's LOAD overwrites it.
    always_comb begin
        pend_hex_d   = pend_hex_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        act_hex_d    = act_hex_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        if (frame_end) begin
            if (pend_valid_q) begin
                act_hex_d = pend_hex_q;
                act_dp_d  = pend_dp_q;
                act_en_d  = pend_en_q;
            end
            pend_valid_d = 1'b0;
        end
        if (LOAD) begin
            pend_hex_d   = HEX;
            pend_dp_d    = DP_IN;
            pend_en_d    = DIGIT_EN;
            pend_valid_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark-for-zero only while every digit above it is dark too.
    always_comb begin
        logic higher_dark;
        higher_dark = 1'b1;
        lz_dark     = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_dark[k]  = higher_dark && (act_hex_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
            higher_dark = higher_dark && (lz_dark[k] || !act_en_q[k]);
        end
    end
`else
    assign lz_dark = '0;
`endif

    always_comb begin
        nibble       = act_hex_q[{idx_q, 2'b00} +: 4];
        shown        = (state_q == ST_DRIVE) && idx_ok && act_en_q[idx_q] && !lz_dark[idx_q];
        anodes_d     = shown ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        cathodes_d   = shown ? ~{seg_decode(nibble), act_dp_q[idx_q]} : 8'hFF;
        frame_done_d = frame_end;
    end

    // NOTE: sequential state uses <= only; all next-state math lives in the always_comb blocks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            // NOTE: the display buffers are plain flops, so they take the reset and the panel stays dark until the first LOAD.
            pend_hex_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            anodes_q     <= '1;
            cathodes_q   <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_hex_q   <= pend_hex_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            act_hex_q    <= act_hex_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ANODES     = anodes_q;
    assign CATHODES   = cathodes_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver: directed frame tables, double-buffer and reset sequences, random loads vs a timeline model.
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic           CLK = 1'b0;
    logic           RST_N;
    logic [4*N-1:0] HEX;
    logic [N-1:0]   DP_IN;
    logic [N-1:0]   DIGIT_EN;
    logic           LOAD;
    logic [7:0]     CATHODES;
    logic [N-1:0]   ANODES;
    logic           FRAME_DONE;

    sevenseg_scan_driver #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .HEX       (HEX),
        .DP_IN     (DP_IN),
        .DIGIT_EN  (DIGIT_EN),
        .LOAD      (LOAD),
        .CATHODES  (CATHODES),
        .ANODES    (ANODES),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4*N-1:0]      hex;
        logic [N-1:0]        dp;
        logic [N-1:0]        en;
        logic [N-1:0][N-1:0] an;
        logic [N-1:0][7:0]   ca;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    // Model of the display buffers; timing is derived from the cycle number alone.
    logic [4*N-1:0] m_hex, m_phex;
    logic [N-1:0]   m_dp, m_pdp, m_en, m_pen;
    logic           m_valid;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0d): got %0h, expected %0h", name, t, got, exp);
        end
    endtask

    task automatic model_clear();
        m_hex = '0; m_phex = '0; m_dp = '0; m_pdp = '0;
        m_en = '0; m_pen = '0; m_valid = 1'b0;
    endtask

    function automatic logic model_lz_dark(input int k);
        logic dark;
        dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (k >= 1 && m_hex[4*k +: 4] == 4'h0 && !m_dp[k]) begin
            dark = 1'b1;
            for (int j = k + 1; j < N; j++)
                if (m_en[j] && !(m_hex[4*j +: 4] == 4'h0 && !m_dp[j])) dark = 1'b0;
        end
`else
        dark = (k < 0);
`endif
        return dark;
    endfunction

    // Outputs visible after clock edge t (t >= 1).
    task automatic model_out(input int tt, output logic [N-1:0] an, output logic [7:0] ca, output logic fd);
        int pos, k, w;
        pos = (tt - 1) % FRAME;
        k   = pos / SLOT;
        w   = pos % SLOT;
        an  = '1;
        ca  = 8'hFF;
        fd  = (pos == FRAME - 1);
        if (w >= BLANK && m_en[k] && !model_lz_dark(k)) begin
            an = ~(N'(1) << k);
            ca = ~{SEG_TAB[m_hex[4*k +: 4]], m_dp[k]};
        end
    endtask

    task automatic tick();
        logic [N-1:0] e_an;
        logic [7:0]   e_ca;
        logic         e_fd, ld;
        @(posedge CLK);
        ld = LOAD;
        t++;
        model_out(t, e_an, e_ca, e_fd);
        if (t % FRAME == 0) begin
            if (m_valid) begin
                m_hex = m_phex; m_dp = m_pdp; m_en = m_pen;
            end
            m_valid = 1'b0;
        end
        if (ld) begin
            m_phex = HEX; m_pdp = DP_IN; m_pen = DIGIT_EN; m_valid = 1'b1;
        end
        @(negedge CLK);
        check("anodes", 32'(ANODES), 32'(e_an));
        check("cathodes", 32'(CATHODES), 32'(e_ca));
        check("frame_done", 32'(FRAME_DONE), 32'(e_fd));
        LOAD = 1'b0;
    endtask

    task automatic load(input logic [4*N-1:0] h, input logic [N-1:0] d, input logic [N-1:0] e);
        HEX = h; DP_IN = d; DIGIT_EN = e; LOAD = 1'b1;
        tick();
    endtask

    task automatic run_to(input int phase);
        while (t % FRAME != phase) tick();
    endtask

    task automatic show_frame(input int id, input vec_t v);
        int pos, k;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            pos = (t - 1) % FRAME;
            if (pos % SLOT == BLANK + 1) begin
                k = pos / SLOT;
                check($sformatf("tbl%0d_an_d%0d", id, k), 32'(ANODES), 32'(v.an[k]));
                check($sformatf("tbl%0d_ca_d%0d", id, k), 32'(CATHODES), 32'(v.ca[k]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        logic [4*N-1:0] rh;
        logic [N-1:0]   rd, re;
        int pos;

        tbl[0] = '{hex: 16'h3A0F, dp: 4'b0000, en: 4'b1111,
                   an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   ca: {8'b00001101, 8'b00010001, 8'b00000011, 8'b01110001}};
        tbl[1] = '{hex: 16'h3A0F, dp: 4'b0010, en: 4'b1011,
                   an: {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                   ca: {8'b00001101, 8'hFF, 8'b00000010, 8'b01110001}};
        tbl[2] = '{hex: 16'h1234, dp: 4'b0000, en: 4'b1111,
                   an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   ca: {8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001}};
        tbl[3] = '{hex: 16'hCE96, dp: 4'b1001, en: 4'b1111,
                   an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   ca: {8'b01100010, 8'b01100001, 8'b00001001, 8'b01000000}};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[4] = '{hex: 16'h0070, dp: 4'b0000, en: 4'b1111,
                   an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                   ca: {8'hFF, 8'hFF, 8'b00011111, 8'b00000011}};
        tbl[5] = '{hex: 16'h0000, dp: 4'b0000, en: 4'b1111,
                   an: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                   ca: {8'hFF, 8'hFF, 8'hFF, 8'b00000011}};
`else
        tbl[4] = '{hex: 16'h0070, dp: 4'b0000, en: 4'b1111,
                   an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   ca: {8'b00000011, 8'b00000011, 8'b00011111, 8'b00000011}};
        tbl[5] = '{hex: 16'h0000, dp: 4'b0000, en: 4'b1111,
                   an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   ca: {8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011}};
`endif

        RST_N = 1'b0; LOAD = 1'b0; HEX = '0; DP_IN = '0; DIGIT_EN = '0;
        model_clear();
        #12;
        check("rst_anodes", 32'(ANODES), 32'hF);
        check("rst_cathodes", 32'(CATHODES), 32'hFF);
        check("rst_frame_done", 32'(FRAME_DONE), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        t = 0;

        // Dark until a LOAD reaches the active buffer; first boundary on clock 24.
        while (t < 30) begin
            tick();
            check("idle_anodes", 32'(ANODES), 32'hF);
            check("idle_cathodes", 32'(CATHODES), 32'hFF);
            check("idle_frame_done", 32'(FRAME_DONE), 32'(t == 24));
        end

        for (int i = 0; i < 6; i++) begin
            if ((t + 1) % FRAME == 0) tick();
            load(tbl[i].hex, tbl[i].dp, tbl[i].en);
            run_to(0);
            show_frame(i, tbl[i]);
        end

        // LOAD mid-frame, then LOAD again on the FRAME_DONE clock.
        run_to(10);
        load(16'h1234, 4'b0000, 4'b1111);
        run_to(FRAME - 1);
        load(16'h5678, 4'b0000, 4'b1111);
        check("dbuf_boundary_fd", 32'(FRAME_DONE), 32'h1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            pos = (t - 1) % FRAME;
            if (pos == BLANK + 1)
                check("dbuf_d0", 32'(CATHODES), (i < FRAME) ? 32'b10011001 : 32'b00000001);
            if (pos == 3 * SLOT + BLANK + 1)
                check("dbuf_d3", 32'(CATHODES), (i < FRAME) ? 32'b10011111 : 32'b01001001);
        end

        // Asynchronous reset while digit 0 is being driven.
        run_to(4);
        check("pre_rst_anodes", 32'(ANODES), 32'b1110);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_anodes", 32'(ANODES), 32'hF);
        check("async_rst_cathodes", 32'(CATHODES), 32'hFF);
        check("async_rst_frame_done", 32'(FRAME_DONE), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        t = 0;
        model_clear();
        tick();
        tick();
        load(16'h3A0F, 4'b0000, 4'b1111);
        while (t < 30) begin
            tick();
            if (t == 24) check("restart_frame_done", 32'(FRAME_DONE), 32'h1);
            if (t == 26) check("restart_blank", 32'(ANODES), 32'hF);
            if (t == 27) begin
                check("restart_d0_anodes", 32'(ANODES), 32'b1110);
                check("restart_d0_cathodes", 32'(CATHODES), 32'b01110001);
            end
        end

        // Random LOADs, including some that land on frame boundaries.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rh = 16'($urandom) >> (4 * $urandom_range(0, 4));
                rd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                re = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
                load(rh, rd, re);
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
